// File: rtl/ram_phase_arbiter.sv
// ram_phase_arbiter
//   Owns the single program/data RAM port for one complete run and shares it
//   between the UART receiver (program load), the processor (execution) and
//   the UART transmitter (result dump). It sequences LOAD -> RUN -> DUMP ->
//   DONE and raises UART2RAMCompleted so the control unit may start.
//
// Ports
//   clk, reset          single clock, synchronous active-high reset
//   rx_valid, rx_data   byte pulses from the UART receiver (used in LOAD only)
//   cpu_en/we/addr/wdata  processor RAM request, passed straight through in RUN
//   EndOperations       processor halted (level), sampled in RUN only
//   tx_valid, tx_data, tx_ready  byte stream to the UART transmitter
//   ram_en/we/addr/wdata  RAM port command; ram_rdata arrives one cycle after a read
//   UART2RAMCompleted   load finished, processor may run
//   phase               0 LOAD, 1 RUN, 2 DUMP (all read/transmit states), 3 DONE
//   state_dbg           raw FSM state encoding for observation
//
// Transmit handshake: a byte moves from this block to the transmitter on a
// rising edge where tx_valid and tx_ready are both 1. While tx_valid is 1
// and tx_ready is 0, tx_valid and tx_data hold their values.

module ram_phase_arbiter #(
   parameter int ADDR_W     = 8,
   parameter int LOAD_WORDS = 256,
   parameter int DUMP_BASE  = 0,
   parameter int DUMP_WORDS = 256
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              rx_valid,
   input  logic [7:0]        rx_data,
   input  logic              cpu_en,
   input  logic              cpu_we,
   input  logic [ADDR_W-1:0] cpu_addr,
   input  logic [15:0]       cpu_wdata,
   input  logic              EndOperations,
   input  logic              tx_ready,
   output logic              tx_valid,
   output logic [7:0]        tx_data,
   output logic              ram_en,
   output logic              ram_we,
   output logic [ADDR_W-1:0] ram_addr,
   output logic [15:0]       ram_wdata,
   input  logic [15:0]       ram_rdata,
   output logic              UART2RAMCompleted,
   output logic [1:0]        phase,
   output logic [2:0]        state_dbg
);

   typedef enum logic [2:0] {
      S_LOAD      = 3'd0,
      S_RUN       = 3'd1,
      S_DUMP_RD   = 3'd2,
      S_DUMP_WAIT = 3'd3,
      S_TX_HI     = 3'd4,
      S_TX_LO     = 3'd5,
      S_DONE      = 3'd6
   } state_t;

   localparam logic [ADDR_W:0]   LOAD_N   = (ADDR_W+1)'(LOAD_WORDS);
   localparam logic [ADDR_W:0]   DUMP_N   = (ADDR_W+1)'(DUMP_WORDS);
   localparam logic [ADDR_W-1:0] BASE_A   = ADDR_W'(DUMP_BASE);
   localparam logic [ADDR_W:0]   CNT_ONE  = (ADDR_W+1)'(1);
   localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);

   state_t            state;
   logic [ADDR_W:0]   load_cnt;
   logic [7:0]        hi_buf;
   logic              hi_flag;
   logic [ADDR_W-1:0] dump_ptr;
   logic [ADDR_W:0]   dump_cnt;
   logic [15:0]       tx_buf;
   logic              completed;
   logic              load_word;

   // Second byte of a pair: the word is written in this very cycle.
   assign load_word = (state == S_LOAD) && rx_valid && hi_flag;

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= S_LOAD;
         load_cnt  <= '0;
         hi_buf    <= '0;
         hi_flag   <= 1'b0;
         dump_ptr  <= '0;
         dump_cnt  <= '0;
         tx_buf    <= '0;
         completed <= 1'b0;
      end else begin
         case (state)
            S_LOAD: begin
               if (rx_valid) begin
                  if (!hi_flag) begin
                     hi_buf  <= rx_data;
                     hi_flag <= 1'b1;
                  end else begin
                     hi_flag  <= 1'b0;
                     load_cnt <= load_cnt + CNT_ONE;
                     // Leave LOAD on the edge that completes the last write.
                     if (load_cnt + CNT_ONE == LOAD_N) begin
                        state     <= S_RUN;
                        completed <= 1'b1;
                     end
                  end
               end
            end
            S_RUN: begin
               if (EndOperations) begin
                  state    <= S_DUMP_RD;
                  dump_ptr <= BASE_A;
                  dump_cnt <= '0;
               end
            end
            S_DUMP_RD: state <= S_DUMP_WAIT;
            S_DUMP_WAIT: begin
               tx_buf <= ram_rdata;
               state  <= S_TX_HI;
            end
            S_TX_HI: begin
               if (tx_ready) state <= S_TX_LO;
            end
            S_TX_LO: begin
               if (tx_ready) begin
                  dump_ptr <= dump_ptr + ADDR_ONE;   // wraps modulo 2^ADDR_W
                  dump_cnt <= dump_cnt + CNT_ONE;
                  if (dump_cnt + CNT_ONE == DUMP_N) state <= S_DONE;
                  else                              state <= S_DUMP_RD;
               end
            end
            S_DONE:  state <= S_DONE;
            default: state <= S_LOAD;
         endcase
      end
   end

   // RAM port mux: decoded from the registered state plus the live inputs of
   // the current owner, so load writes and processor accesses add no latency.
   always_comb begin
      ram_en    = 1'b0;
      ram_we    = 1'b0;
      ram_addr  = '0;
      ram_wdata = '0;
      case (state)
         S_LOAD: begin
            if (load_word) begin
               ram_en    = 1'b1;
               ram_we    = 1'b1;
               ram_addr  = load_cnt[ADDR_W-1:0];
               ram_wdata = {hi_buf, rx_data};
            end
         end
         S_RUN: begin
            ram_en    = cpu_en;
            ram_we    = cpu_we;
            ram_addr  = cpu_addr;
            ram_wdata = cpu_wdata;
         end
         S_DUMP_RD: begin
            ram_en   = 1'b1;
            ram_addr = dump_ptr;
         end
         default: ;
      endcase
   end

   always_comb begin
      tx_valid = 1'b0;
      tx_data  = 8'h00;
      phase    = 2'd2;
      case (state)
         S_LOAD: phase = 2'd0;
         S_RUN:  phase = 2'd1;
         S_DONE: phase = 2'd3;
         S_TX_HI: begin
            tx_valid = 1'b1;
            tx_data  = tx_buf[15:8];
         end
         S_TX_LO: begin
            tx_valid = 1'b1;
            tx_data  = tx_buf[7:0];
         end
         default: ;
      endcase
   end

   assign UART2RAMCompleted = completed;
   assign state_dbg         = state;

endmodule

// File: tb/tb_ram_phase_arbiter.sv
module tb_ram_phase_arbiter;

   logic        clk = 1'b0;
   logic        reset;
   logic        rx_valid;
   logic [7:0]  rx_data;
   logic        cpu_en;
   logic        cpu_we;
   logic [7:0]  cpu_addr;
   logic [15:0] cpu_wdata;
   logic        EndOperations;
   logic        tx_ready;
   logic        tx_valid;
   logic [7:0]  tx_data;
   logic        ram_en;
   logic        ram_we;
   logic [7:0]  ram_addr;
   logic [15:0] ram_wdata;
   logic [15:0] ram_rdata;
   logic        UART2RAMCompleted;
   logic [1:0]  phase;
   logic [2:0]  state_dbg;

   int vectors = 0;
   int miscompares = 0;

   // Stimulus tables (hand-derived expectations).
   logic [7:0]  load_bytes [8] = '{8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC, 8'hDE, 8'hF0};
   logic [15:0] load_words [4] = '{16'h1234, 16'h5678, 16'h9ABC, 16'hDEF0};
   logic [7:0]  dump_addr  [3] = '{8'hFE, 8'hFF, 8'h00};
   logic [7:0]  dump_hi    [3] = '{8'h11, 8'h22, 8'h33};
   logic [7:0]  dump_lo    [3] = '{8'h11, 8'h22, 8'h33};

   logic [15:0] mem [256];

   always #5 clk = ~clk;

   ram_phase_arbiter #(
      .ADDR_W(8), .LOAD_WORDS(4), .DUMP_BASE(254), .DUMP_WORDS(3)
   ) dut (
      .clk(clk), .reset(reset),
      .rx_valid(rx_valid), .rx_data(rx_data),
      .cpu_en(cpu_en), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
      .EndOperations(EndOperations),
      .tx_ready(tx_ready), .tx_valid(tx_valid), .tx_data(tx_data),
      .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
      .ram_rdata(ram_rdata),
      .UART2RAMCompleted(UART2RAMCompleted), .phase(phase), .state_dbg(state_dbg)
   );

   // Synchronous RAM: read data appears one cycle after a read command.
   always @(posedge clk) begin
      if (ram_en) begin
         if (ram_we) mem[ram_addr] <= ram_wdata;
         else        ram_rdata     <= mem[ram_addr];
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Advance to the next falling edge; inputs are driven there and outputs
   // checked #1 later, well away from the rising edge.
   task automatic cyc();
      @(negedge clk);
   endtask

   task automatic chk_ram_idle(input string tag);
      chk({tag, "_ram_en"},    ram_en,    0);
      chk({tag, "_ram_we"},    ram_we,    0);
      chk({tag, "_ram_addr"},  ram_addr,  0);
      chk({tag, "_ram_wdata"}, ram_wdata, 0);
   endtask

   task automatic load_all();
      for (int i = 0; i < 8; i++) begin
         cyc();
         rx_valid = 1'b1;
         rx_data  = load_bytes[i];
         #1;
         if (i % 2 == 1) begin
            chk($sformatf("load%0d_en", i),    ram_en,    1);
            chk($sformatf("load%0d_we", i),    ram_we,    1);
            chk($sformatf("load%0d_addr", i),  ram_addr,  i / 2);
            chk($sformatf("load%0d_wdata", i), ram_wdata, load_words[i / 2]);
         end else begin
            chk($sformatf("load%0d_noen", i), ram_en, 0);
         end
         chk($sformatf("load%0d_phase", i), phase, 0);
         chk($sformatf("load%0d_cmpl", i),  UART2RAMCompleted, 0);
      end
   endtask

   initial begin
      reset = 1'b1; rx_valid = 1'b0; rx_data = 8'h00;
      cpu_en = 1'b0; cpu_we = 1'b0; cpu_addr = 8'h00; cpu_wdata = 16'h0000;
      EndOperations = 1'b0; tx_ready = 1'b0;

      // ---- reset state
      cyc(); cyc(); #1;
      chk_ram_idle("rst");
      chk("rst_tx_valid", tx_valid, 0);
      chk("rst_tx_data",  tx_data,  0);
      chk("rst_cmpl",     UART2RAMCompleted, 0);
      chk("rst_phase",    phase, 0);
      chk("rst_state",    state_dbg, 0);

      // ---- reset after an odd byte count discards the pending high byte
      cyc(); reset = 1'b0; rx_valid = 1'b1; rx_data = 8'hAA; #1;
      chk("odd_byte_noen", ram_en, 0);
      cyc(); rx_valid = 1'b0; reset = 1'b1;
      cyc(); reset = 1'b0; #1;
      chk_ram_idle("midrst");
      chk("midrst_phase", phase, 0);
      chk("midrst_cmpl",  UART2RAMCompleted, 0);

      // ---- processor requests in LOAD produce no RAM activity
      cyc(); cpu_en = 1'b1; cpu_we = 1'b1; cpu_addr = 8'h20; cpu_wdata = 16'hBEEF; #1;
      chk_ram_idle("load_cpu");
      cpu_en = 1'b0; cpu_we = 1'b0;

      // ---- load four words; first word proves the 0xAA byte was dropped
      load_all();
      cyc(); rx_valid = 1'b0;
      // first RUN cycle: processor owns the port immediately
      cpu_en = 1'b1; cpu_we = 1'b1; cpu_addr = 8'h20; cpu_wdata = 16'hBEEF; #1;
      chk("run_cmpl",  UART2RAMCompleted, 1);
      chk("run_phase", phase, 1);
      chk("run_en",    ram_en, 1);
      chk("run_we",    ram_we, 1);
      chk("run_addr",  ram_addr, 8'h20);
      chk("run_wdata", ram_wdata, 16'hBEEF);
      chk("mem0_loaded", mem[0], 16'h1234);
      chk("mem3_loaded", mem[3], 16'hDEF0);

      // processor seeds the dump window, wrapping across FF -> 00
      cyc(); cpu_addr = 8'hFE; cpu_wdata = 16'h1111;
      cyc(); cpu_addr = 8'hFF; cpu_wdata = 16'h2222;
      cyc(); cpu_addr = 8'h00; cpu_wdata = 16'h3333;
      #1; chk("run_addr00", ram_addr, 8'h00);

      // stray byte pair in RUN must not touch RAM
      cyc(); cpu_en = 1'b0; cpu_we = 1'b0; rx_valid = 1'b1; rx_data = 8'h55; #1;
      chk("stray0_en", ram_en, 0);
      cyc(); rx_data = 8'h66; #1;
      chk("stray1_en", ram_en, 0);
      cyc(); rx_valid = 1'b0; #1;
      chk("mem1_kept",  mem[1], 16'h5678);
      chk("mem2_kept",  mem[2], 16'h9ABC);
      chk("mem0_cpu",   mem[0], 16'h3333);
      chk("memFF_cpu",  mem[255], 16'h2222);

      // ---- halt; processor inputs become irrelevant afterwards
      cyc(); EndOperations = 1'b1; #1;
      chk("halt_phase", phase, 1);
      cyc(); EndOperations = 1'b0;
      cpu_en = 1'b1; cpu_we = 1'b1; cpu_addr = 8'h44; cpu_wdata = 16'hDEAD; #1;
      chk("rd0_phase", phase, 2);
      chk("rd0_en",    ram_en, 1);
      chk("rd0_we",    ram_we, 0);
      chk("rd0_addr",  ram_addr, 8'hFE);
      chk("rd0_txv",   tx_valid, 0);
      cyc(); #1;
      chk_ram_idle("wait0");
      chk("wait0_txv", tx_valid, 0);

      // ---- backpressure: five TX_HI cycles with tx_ready low
      for (int k = 0; k < 5; k++) begin
         cyc(); #1;
         chk($sformatf("bp%0d_txv", k),  tx_valid, 1);
         chk($sformatf("bp%0d_txd", k),  tx_data, 8'h11);
         chk($sformatf("bp%0d_ren", k),  ram_en, 0);
      end
      cyc(); tx_ready = 1'b1; #1;
      chk("hi0_txv", tx_valid, 1);
      chk("hi0_txd", tx_data, dump_hi[0]);
      cyc(); #1;
      chk("lo0_txv", tx_valid, 1);
      chk("lo0_txd", tx_data, dump_lo[0]);

      // ---- remaining words at full rate, 4 cycles each
      for (int w = 1; w < 3; w++) begin
         cyc(); #1;
         chk($sformatf("rd%0d_en", w),   ram_en, 1);
         chk($sformatf("rd%0d_we", w),   ram_we, 0);
         chk($sformatf("rd%0d_addr", w), ram_addr, dump_addr[w]);
         chk($sformatf("rd%0d_txv", w),  tx_valid, 0);
         cyc(); #1;
         chk($sformatf("wait%0d_txv", w), tx_valid, 0);
         chk($sformatf("wait%0d_en", w),  ram_en, 0);
         cyc(); #1;
         chk($sformatf("hi%0d_txv", w), tx_valid, 1);
         chk($sformatf("hi%0d_txd", w), tx_data, dump_hi[w]);
         cyc(); #1;
         chk($sformatf("lo%0d_txv", w), tx_valid, 1);
         chk($sformatf("lo%0d_txd", w), tx_data, dump_lo[w]);
      end

      // ---- DONE holds with everything quiet
      for (int k = 0; k < 2; k++) begin
         cyc(); #1;
         chk($sformatf("done%0d_phase", k), phase, 3);
         chk($sformatf("done%0d_cmpl", k),  UART2RAMCompleted, 1);
         chk($sformatf("done%0d_txv", k),   tx_valid, 0);
         chk($sformatf("done%0d_txd", k),   tx_data, 0);
         chk_ram_idle($sformatf("done%0d", k));
      end

      // ---- second run: EndOperations already high during LOAD
      cyc(); reset = 1'b1; cpu_en = 1'b0; cpu_we = 1'b0;
      cyc(); reset = 1'b0; EndOperations = 1'b1; tx_ready = 1'b0; #1;
      chk("rst2_phase", phase, 0);
      chk("rst2_cmpl",  UART2RAMCompleted, 0);
      chk("rst2_txv",   tx_valid, 0);
      load_all();
      cyc(); rx_valid = 1'b0; #1;
      chk("early_run_phase", phase, 1);
      chk("early_run_cmpl",  UART2RAMCompleted, 1);
      cyc(); #1;
      chk("early_rd_phase", phase, 2);
      chk("early_rd_en",    ram_en, 1);
      chk("early_rd_addr",  ram_addr, 8'hFE);
      chk("early_mem0",     mem[0], 16'h1234);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/ram_phase_arbiter.md
# ram_phase_arbiter

Owns the single program/data RAM port and shares it between three requesters across the life of a run: the UART receiver during program load, the processor during execution, and the UART transmitter during result dump. Sits between the UART blocks, the processor core and the RAM. Generates the `UART2RAMCompleted` qualifier that gates the control unit. Sequences the full load → run → dump → done flow.

## Interface
Parameters:
- `ADDR_W`, 8, RAM word-address width.
- `LOAD_WORDS`, 256, number of 16-bit words loaded from UART. Range 1..2^ADDR_W.
- `DUMP_BASE`, 0, first word address sent back after halt.
- `DUMP_WORDS`, 256, number of words dumped. Range 1..2^ADDR_W. Addresses wrap modulo 2^ADDR_W.

Ports:
- `clk` in 1: single clock; all state changes on its rising edge.
- `reset` in 1: synchronous, active-high.
- `rx_valid` in 1: one-cycle pulse, byte available from UART receiver.
- `rx_data` in 8: received byte.
- `cpu_en` in 1: processor RAM access request.
- `cpu_we` in 1: processor write enable.
- `cpu_addr` in ADDR_W: processor address.
- `cpu_wdata` in 16: processor write data.
- `EndOperations` in 1: processor halted; level.
- `tx_ready` in 1: UART transmitter can accept a byte.
- `tx_valid` out 1: byte offered to transmitter.
- `tx_data` out 8: byte offered.
- `ram_en` out 1: RAM port enable.
- `ram_we` out 1: RAM write enable.
- `ram_addr` out ADDR_W: RAM address.
- `ram_wdata` out 16: RAM write data.
- `ram_rdata` in 16: RAM read data, valid one cycle after a read. The processor also reads this directly.
- `UART2RAMCompleted` out 1: load finished; processor may run.
- `phase` out 2: 0 = LOAD, 1 = RUN, 2 = DUMP, 3 = DONE.

## Operation
States: LOAD, RUN, DUMP_RD, DUMP_WAIT, TX_HI, TX_LO, DONE. `phase` reports 2 for all DUMP_* and TX_* states.

LOAD:
- Bytes arrive big-endian: the first byte of each pair is latched into `hi_buf` and `hi_flag` is set.
- On the second byte, in the same cycle as its `rx_valid`: `ram_en=1`, `ram_we=1`, `ram_addr=load_cnt[ADDR_W-1:0]`, `ram_wdata={hi_buf, rx_data}`. Then `load_cnt` increments and `hi_flag` clears.
- `load_cnt` is ADDR_W+1 bits wide. When it reaches `LOAD_WORDS`, the next state is RUN and `UART2RAMCompleted` is set.

RUN:
- `ram_en/we/addr/wdata` are driven combinationally from `cpu_*`.
- When `EndOperations`=1 is sampled: go to DUMP_RD, set `dump_ptr=DUMP_BASE`, clear `dump_cnt`.
- From the following cycle on, `cpu_*` are ignored.

Dump sequence:
- DUMP_RD: `ram_en=1`, `ram_we=0`, `ram_addr=dump_ptr`. Next state DUMP_WAIT.
- DUMP_WAIT: capture `ram_rdata` into `tx_buf`. Next state TX_HI.
- TX_HI: `tx_valid=1`, `tx_data=tx_buf[15:8]`. Advance only on `tx_ready`=1.
- TX_LO: `tx_valid=1`, `tx_data=tx_buf[7:0]`. On `tx_ready`=1: increment `dump_ptr` (wraps) and `dump_cnt`. If `dump_cnt+1==DUMP_WORDS`, go to DONE; else go to DUMP_RD.

DONE:
- All RAM and tx outputs are 0.
- `UART2RAMCompleted` stays 1.
- Held until `reset`.

Rules:
- `rx_valid` outside LOAD is ignored.
- `EndOperations` is sampled only in RUN. If it is high during LOAD, it has no effect until RUN.
- `UART2RAMCompleted` is 0 in LOAD and 1 in every other state.
- In non-RUN states, RAM outputs are 0 except when the state drives them as described above.

## Timing
- Reset values: state LOAD; all counters, `hi_buf`, `hi_flag` and `tx_buf` 0; `UART2RAMCompleted`=0, `phase`=0, `tx_valid`=0, `tx_data`=0, `ram_en`=0, `ram_we`=0, `ram_addr`=0, `ram_wdata`=0.
- Reset asserted mid-operation aborts everything the next edge. A pending high byte is discarded, and a transmit in progress is dropped without completing the byte pair.
- Load write latency: 0 cycles. The write happens in the cycle of the second `rx_valid`.
- `UART2RAMCompleted` rises on the edge after the last load write. The processor gets the port that same cycle.
- RUN muxing is purely combinational: no added latency on processor accesses.
- Halt to first `tx_valid`: 3 cycles. The edge sampling `EndOperations` enters DUMP_RD, then DUMP_WAIT, then TX_HI.
- Per word with `tx_ready` held high: 4 cycles.
- `tx_valid` and `tx_data` are stable while `tx_ready`=0.
- Back-to-back `rx_valid` on consecutive cycles is supported.

## Test plan
- Load: `LOAD_WORDS`=4, send bytes 12 34 56 78 9A BC DE F0. Required: RAM writes 0:1234, 1:5678, 2:9ABC, 3:DEF0, each in its second-byte cycle. `UART2RAMCompleted` rises one cycle after the last write; `phase`=1.
- Run mux: in RUN, `cpu_en`=1, `cpu_we`=1, `cpu_addr`=0x20, `cpu_wdata`=0xBEEF. Required: identical values on the `ram_*` ports in the same cycle. In LOAD, the same `cpu_*` stimulus produces no RAM activity.
- Dump: `DUMP_BASE`=0xFE, `DUMP_WORDS`=3, RAM FE:1111, FF:2222, 00:3333, `tx_ready`=1. Required: bytes 11 11 22 22 33 33 and address wrap FF→00, then DONE.
- Backpressure: during TX_HI, hold `tx_ready`=0 for 5 cycles. Required: `tx_valid`=1 and `tx_data` unchanged throughout, no RAM read, and progress resumes the cycle `tx_ready` returns.
- Early and stray inputs: `EndOperations`=1 during LOAD and an extra `rx_valid` during RUN. Required: load completes normally, RAM is unchanged by the stray byte, and the dump starts in the first RUN cycle.
- Reset mid-load: reset after an odd byte count. Required: all outputs at reset values; the next two bytes form the word at address 0.
